// File: rtl/clock_period_meter.sv
// clock_period_meter: period and high-time meter for a slow asynchronous clock, in iclk cycles.
// Optional lock detector is built only when CLKMEAS_LOCK_EN is defined.
module clock_period_meter #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 1_000_000,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2
) (
  input  logic             iclk,
  input  logic             reset_n,
  input  logic             sclk,
  input  logic             meas_en,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             timeout,
  output logic             locked
);

  if (SYNC_STAGES < 2 || TIMEOUT < 2 || LOCK_TOL < 0) begin : g_bad_param
    $error("clock_period_meter: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE,
    MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;
  logic                   fall;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nx;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] period_nx;
  logic [CNT_W-1:0] high_nx;
  logic             valid_nx;
  logic             to_nx;
  logic             at_last;

  always_ff @(posedge iclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sclk};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise      = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall      = ~sync_q[SYNC_STAGES-1] & hist_q;
  assign count_inc = count + CNT_W'(1);
  assign at_last   = (count == TO_LAST);

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    period_nx = period;
    high_nx   = high_time;
    valid_nx  = 1'b0;
    to_nx     = timeout;
    if (!meas_en) begin
      state_nx = IDLE;
      count_nx = '0;
      to_nx    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          count_nx = '0;
          state_nx = WAIT_EDGE;
        end
        WAIT_EDGE: begin
          // first edge only aligns the measurement window
          if (rise) begin
            count_nx = '0;
            state_nx = MEASURE;
          end else if (at_last) begin
            to_nx    = 1'b1;
            count_nx = '0;
          end else begin
            count_nx = count_inc;
          end
        end
        MEASURE: begin
          count_nx = count_inc;
          if (fall) high_nx = count_inc;
          if (rise) begin
            period_nx = count_inc;
            valid_nx  = 1'b1;
            count_nx  = '0;
            to_nx     = 1'b0;
          end else if (at_last) begin
            to_nx    = 1'b1;
            count_nx = '0;
            state_nx = WAIT_EDGE;
          end
        end
        default: begin
          state_nx = IDLE;
          count_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge iclk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      count        <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nx;
      count        <= count_nx;
      period       <= period_nx;
      high_time    <= high_nx;
      period_valid <= valid_nx;
      timeout      <= to_nx;
    end
  end

`ifdef CLKMEAS_LOCK_EN
  logic             have_prev;
  logic             lock_upd;
  logic             lock_clr;
  logic             close;
  logic [CNT_W-1:0] diff;

  always_comb begin
    lock_upd = 1'b0;
    lock_clr = 1'b0;
    if (!meas_en) begin
      lock_clr = 1'b1;
    end else if (state == MEASURE) begin
      lock_upd = rise;
      lock_clr = !rise && at_last;
    end
  end

  assign diff  = (count_inc >= period) ? (count_inc - period)
                                       : (period - count_inc);
  assign close = (diff <= CNT_W'(LOCK_TOL));

  // lock needs a previous period from the same measurement session
  always_ff @(posedge iclk or negedge reset_n) begin
    if (!reset_n) begin
      have_prev <= 1'b0;
      locked    <= 1'b0;
    end else if (lock_clr) begin
      have_prev <= 1'b0;
      locked    <= 1'b0;
    end else if (lock_upd) begin
      have_prev <= 1'b1;
      locked    <= have_prev & close;
    end
  end
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: randomized and directed checks of clock_period_meter
// against a waveform-level reference model.
`timescale 1ns/1ps
module tb_clock_period_meter;

`ifdef CLKMEAS_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        iclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        meas_en = 1'b0;
  logic [31:0] period;
  logic [31:0] high_time;
  logic        period_valid;
  logic        timeout;
  logic        locked;

  logic        sclk2 = 1'b0;
  logic        meas_en2 = 1'b0;
  logic [31:0] period2;
  logic [31:0] high2;
  logic        valid2;
  logic        timeout2;
  logic        locked2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int wp[$];
  int wh[$];
  int obs_p[$];
  int obs_h[$];
  bit obs_l[$];
  int obs_t[$];
  int big_cnt = 0;
  int big_p = 0;
  int big_h = 0;

  clock_period_meter #(
    .CNT_W(32), .TIMEOUT(100), .SYNC_STAGES(2), .LOCK_TOL(2)
  ) dut (
    .iclk(iclk), .reset_n(rst_n), .sclk(sclk), .meas_en(meas_en),
    .period(period), .high_time(high_time), .period_valid(period_valid),
    .timeout(timeout), .locked(locked)
  );

  clock_period_meter #(
    .CNT_W(32), .TIMEOUT(30000), .SYNC_STAGES(2), .LOCK_TOL(2)
  ) dut_big (
    .iclk(iclk), .reset_n(rst_n), .sclk(sclk2), .meas_en(meas_en2),
    .period(period2), .high_time(high2), .period_valid(valid2),
    .timeout(timeout2), .locked(locked2)
  );

  always #5 iclk = ~iclk;

  always @(posedge iclk) cyc <= cyc + 1;

  always @(negedge iclk) begin
    if (period_valid === 1'b1) begin
      obs_p.push_back(int'(period));
      obs_h.push_back(int'(high_time));
      obs_l.push_back(locked);
      obs_t.push_back(cyc);
    end
    if (valid2 === 1'b1) begin
      big_cnt++;
      big_p = int'(period2);
      big_h = int'(high2);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge iclk);
    #1;
  endtask

  // expected lock after the k-th period of the current session
  function automatic bit exp_lock(input int k);
    int d;
    if (!LOCK_EN || k == 0) return 1'b0;
    d = wp[k] - wp[k-1];
    if (d < 0) d = -d;
    return d <= 2;
  endfunction

  task automatic clear_obs();
    obs_p.delete();
    obs_h.delete();
    obs_l.delete();
    obs_t.delete();
  endtask

  // drives every waveform in wp/wh, then one closing rise
  task automatic run_seq(input bit keep_en);
    clear_obs();
    meas_en = 1'b1;
    sclk = 1'b0;
    wait_cycles(4);
    foreach (wp[i]) begin
      sclk = 1'b1;
      wait_cycles(wh[i]);
      sclk = 1'b0;
      wait_cycles(wp[i] - wh[i]);
    end
    sclk = 1'b1;
    wait_cycles(3);
    sclk = 1'b0;
    wait_cycles(8);
    if (!keep_en) begin
      meas_en = 1'b0;
      wait_cycles(2);
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (period !== 0 || high_time !== 0 || period_valid !== 0 ||
        timeout !== 0 || locked !== 0) begin
      n_bad++;
      $display("FAIL reset_outputs: got p=%0d h=%0d v=%b t=%b l=%b, required all 0",
               period, high_time, period_valid, timeout, locked);
    end
    n_cmp++;
    if (period2 !== 0 || high2 !== 0 || valid2 !== 0 ||
        timeout2 !== 0 || locked2 !== 0) begin
      n_bad++;
      $display("FAIL reset_outputs_big: got p=%0d h=%0d, required 0", period2, high2);
    end
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_timeout();
    int n;
    clear_obs();
    sclk = 1'b0;
    meas_en = 1'b1;
    n = 0;
    while (timeout !== 1'b1 && n < 200) begin
      wait_cycles(1);
      n++;
    end
    n_cmp++;
    if (n != 101) begin
      n_bad++;
      $display("FAIL timeout_latency: got %0d cycles, required 101", n);
    end
    wait_cycles(30);
    n_cmp++;
    if (timeout !== 1'b1 || period !== 0 || obs_p.size() != 0) begin
      n_bad++;
      $display("FAIL timeout_sticky: got t=%b p=%0d valids=%0d, required t=1 p=0 valids=0",
               timeout, period, obs_p.size());
    end
    meas_en = 1'b0;
    wait_cycles(2);
    n_cmp++;
    if (timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_clear: got %b, required 0", timeout);
    end
  endtask

  task automatic test_fixed();
    wp.delete();
    wh.delete();
    repeat (6) begin
      wp.push_back(10);
      wh.push_back(5);
    end
    run_seq(1'b0);
    n_cmp++;
    if (obs_p.size() != wp.size()) begin
      n_bad++;
      $display("FAIL fixed_count: got %0d valids, required %0d", obs_p.size(), wp.size());
    end
    for (int i = 0; i < obs_p.size() && i < wp.size(); i++) begin
      n_cmp++;
      if (obs_p[i] != 10 || obs_h[i] != 5 || obs_l[i] != exp_lock(i) ||
          (i > 0 && obs_t[i] - obs_t[i-1] != 10)) begin
        n_bad++;
        $display("FAIL fixed_%0d: got p=%0d h=%0d l=%b, required p=10 h=5 l=%b spacing 10",
                 i, obs_p[i], obs_h[i], obs_l[i], exp_lock(i));
      end
    end
  endtask

  task automatic test_random();
    int p;
    for (int r = 0; r < 3; r++) begin
      wp.delete();
      wh.delete();
      repeat (10) begin
        p = $urandom_range(40, 2);
        wp.push_back(p);
        wh.push_back($urandom_range(p - 1, 1));
      end
      run_seq(1'b0);
      n_cmp++;
      if (obs_p.size() != wp.size()) begin
        n_bad++;
        $display("FAIL random_count: got %0d valids, required %0d", obs_p.size(), wp.size());
      end
      for (int i = 0; i < obs_p.size() && i < wp.size(); i++) begin
        n_cmp++;
        if (obs_p[i] != wp[i] || obs_h[i] != wh[i] || obs_l[i] != exp_lock(i)) begin
          n_bad++;
          $display("FAIL random_%0d_%0d: got p=%0d h=%0d l=%b, required p=%0d h=%0d l=%b",
                   r, i, obs_p[i], obs_h[i], obs_l[i], wp[i], wh[i], exp_lock(i));
        end
      end
    end
  endtask

  task automatic test_lock();
    wp.delete();
    wh.delete();
    wp.push_back(10); wh.push_back(5);
    wp.push_back(11); wh.push_back(5);
    wp.push_back(20); wh.push_back(5);
    run_seq(1'b0);
    n_cmp++;
    if (obs_l.size() != 3) begin
      n_bad++;
      $display("FAIL lock_count: got %0d valids, required 3", obs_l.size());
    end
    for (int i = 0; i < obs_l.size() && i < 3; i++) begin
      n_cmp++;
      if (obs_l[i] != exp_lock(i) || obs_p[i] != wp[i]) begin
        n_bad++;
        $display("FAIL lock_%0d: got l=%b p=%0d, required l=%b p=%0d",
                 i, obs_l[i], obs_p[i], exp_lock(i), wp[i]);
      end
    end
  endtask

  task automatic test_meas_en();
    int p;
    wp.delete();
    wh.delete();
    repeat (4) begin
      wp.push_back(10);
      wh.push_back(5);
    end
    run_seq(1'b1);
    n_cmp++;
    if (locked !== LOCK_EN || period !== 10) begin
      n_bad++;
      $display("FAIL steady_state: got l=%b p=%0d, required l=%b p=10", locked, period, LOCK_EN);
    end
    clear_obs();
    meas_en = 1'b0;
    wait_cycles(5);
    n_cmp++;
    if (timeout !== 0 || locked !== 0 || period !== 10 || obs_p.size() != 0) begin
      n_bad++;
      $display("FAIL meas_en_off: got t=%b l=%b p=%0d valids=%0d, required 0 0 10 0",
               timeout, locked, period, obs_p.size());
    end
    wp.delete();
    wh.delete();
    repeat (3) begin
      p = $urandom_range(30, 4);
      wp.push_back(p);
      wh.push_back($urandom_range(p - 1, 1));
    end
    run_seq(1'b0);
    n_cmp++;
    if (obs_p.size() != 3) begin
      n_bad++;
      $display("FAIL realign_count: got %0d valids, required 3", obs_p.size());
    end
    for (int i = 0; i < obs_p.size() && i < 3; i++) begin
      n_cmp++;
      if (obs_p[i] != wp[i] || obs_h[i] != wh[i] || obs_l[i] != exp_lock(i)) begin
        n_bad++;
        $display("FAIL realign_%0d: got p=%0d h=%0d l=%b, required p=%0d h=%0d l=%b",
                 i, obs_p[i], obs_h[i], obs_l[i], wp[i], wh[i], exp_lock(i));
      end
    end
  endtask

  task automatic test_meas_timeout();
    int n;
    clear_obs();
    meas_en = 1'b1;
    sclk = 1'b0;
    wait_cycles(4);
    sclk = 1'b1; wait_cycles(5);
    sclk = 1'b0; wait_cycles(5);
    sclk = 1'b1; wait_cycles(5);
    sclk = 1'b0;
    n = 0;
    while (timeout !== 1'b1 && n < 150) begin
      wait_cycles(1);
      n++;
    end
    n_cmp++;
    if (timeout !== 1'b1 || period !== 10 || high_time !== 5 || locked !== 0) begin
      n_bad++;
      $display("FAIL measure_timeout: got t=%b p=%0d h=%0d l=%b, required 1 10 5 0",
               timeout, period, high_time, locked);
    end
    sclk = 1'b1; wait_cycles(5);
    sclk = 1'b0; wait_cycles(5);
    n_cmp++;
    if (timeout !== 1'b1 || obs_p.size() != 1) begin
      n_bad++;
      $display("FAIL align_after_timeout: got t=%b valids=%0d, required t=1 valids=1",
               timeout, obs_p.size());
    end
    sclk = 1'b1; wait_cycles(3);
    sclk = 1'b0; wait_cycles(8);
    n_cmp++;
    if (obs_p.size() != 2 || timeout !== 1'b0 || period !== 10) begin
      n_bad++;
      $display("FAIL recover_after_timeout: got valids=%0d t=%b p=%0d, required 2 0 10",
               obs_p.size(), timeout, period);
    end
    meas_en = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_reset_mid();
    int p;
    meas_en = 1'b1;
    sclk = 1'b0;
    wait_cycles(4);
    repeat (3) begin
      sclk = 1'b1; wait_cycles(5);
      sclk = 1'b0; wait_cycles(5);
    end
    sclk = 1'b1;
    wait_cycles(2);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (period !== 0 || high_time !== 0 || period_valid !== 0 ||
        timeout !== 0 || locked !== 0) begin
      n_bad++;
      $display("FAIL async_reset: got p=%0d h=%0d v=%b t=%b l=%b, required all 0",
               period, high_time, period_valid, timeout, locked);
    end
    @(posedge iclk);
    #1;
    sclk = 1'b0;
    rst_n = 1'b1;
    wait_cycles(3);
    wp.delete();
    wh.delete();
    repeat (4) begin
      p = $urandom_range(25, 3);
      wp.push_back(p);
      wh.push_back($urandom_range(p - 1, 1));
    end
    run_seq(1'b0);
    n_cmp++;
    if (obs_p.size() != 4) begin
      n_bad++;
      $display("FAIL post_reset_count: got %0d valids, required 4", obs_p.size());
    end
    for (int i = 0; i < obs_p.size() && i < 4; i++) begin
      n_cmp++;
      if (obs_p[i] != wp[i] || obs_h[i] != wh[i]) begin
        n_bad++;
        $display("FAIL post_reset_%0d: got p=%0d h=%0d, required p=%0d h=%0d",
                 i, obs_p[i], obs_h[i], wp[i], wh[i]);
      end
    end
  endtask

  task automatic test_big();
    big_cnt = 0;
    meas_en2 = 1'b1;
    sclk2 = 1'b0;
    wait_cycles(5);
    sclk2 = 1'b1; wait_cycles(12000);
    sclk2 = 1'b0; wait_cycles(12000);
    sclk2 = 1'b1; wait_cycles(3);
    sclk2 = 1'b0; wait_cycles(8);
    n_cmp++;
    if (big_cnt != 1 || big_p != 24000 || big_h != 12000 || timeout2 !== 1'b0) begin
      n_bad++;
      $display("FAIL divider_rate: got valids=%0d p=%0d h=%0d t=%b, required 1 24000 12000 0",
               big_cnt, big_p, big_h, timeout2);
    end
    meas_en2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_fixed();
    test_random();
    test_lock();
    test_meas_en();
    test_meas_timeout();
    test_reset_mid();
    test_big();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
